rr_mux_sel_ctrl: RTL and testbench

- Round-robin select controller for the 4:1 mux stage (inputs a,b,c,d; selects s1,s2).
- Arbitrates four channel requests and drives registered, glitch-free s1/s2 into the mux.
- Holds each grant for a bounded dwell time, or until the downstream consumer acknowledges.
- Reports per-grant completion (done, timeout) to the system.

---
 rtl/rr_mux_sel_ctrl.sv | 95 +++++++++
 tb/tb_rr_mux_sel_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/rr_mux_sel_ctrl.sv
// rr_mux_sel_ctrl: round-robin select controller driving registered, glitch-free s1/s2 for a 4:1 mux.
// Define RR_MUX_SEL_LOCK_EN to add a lock input that suppresses dwell expiry.
module rr_mux_sel_ctrl #(
    parameter int DWELL = 4,
    parameter int CNT_W = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       ack,
`ifdef RR_MUX_SEL_LOCK_EN
    input  logic       lock,
`endif
    output logic       s1,
    output logic       s2,
    output logic [3:0] gnt,
    output logic       valid,
    output logic       done,
    output logic       timeout
);
    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;
    state_t           state, state_nxt;
    logic [1:0]       ptr, ptr_nxt, idx, idx_nxt, off, win;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [7:0]       req2;
    logic [3:0]       rot, gnt_nxt;
    logic             s1_nxt, s2_nxt, valid_nxt, done_nxt, timeout_nxt, expire, finish;
    // Rotate requests so bit 0 is the current highest-priority channel
    assign req2 = {req, req};
    assign rot  = req2[ptr +: 4];
    assign off  = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
    assign win  = ptr + off;
`ifdef RR_MUX_SEL_LOCK_EN
    assign expire = (cnt == '0) && !lock;
`else
    assign expire = cnt == '0;
`endif
    assign finish = ack || !req[idx] || expire;
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            idx     <= '0;
            cnt     <= '0;
            s1      <= 1'b0;
            s2      <= 1'b0;
            gnt     <= '0;
            valid   <= 1'b0;
            done    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            idx     <= idx_nxt;
            cnt     <= cnt_nxt;
            s1      <= s1_nxt;
            s2      <= s2_nxt;
            gnt     <= gnt_nxt;
            valid   <= valid_nxt;
            done    <= done_nxt;
            timeout <= timeout_nxt;
        end
    end
    always_comb begin
        state_nxt = (state == IDLE)  ? ((|req) ? GRANT : IDLE) :
                    (state == GRANT) ? (finish ? RELEASE : GRANT) : IDLE;
    end
    // Selects only move on the IDLE->GRANT edge; RELEASE keeps them stable
    always_comb begin
        ptr_nxt     = ptr;
        idx_nxt     = idx;
        cnt_nxt     = cnt;
        s1_nxt      = s1;
        s2_nxt      = s2;
        gnt_nxt     = gnt;
        valid_nxt   = valid;
        done_nxt    = 1'b0;
        timeout_nxt = 1'b0;
        if (state == IDLE && |req) begin
            idx_nxt          = win;
            {s1_nxt, s2_nxt} = win;
            gnt_nxt          = 4'b0001 << win;
            valid_nxt        = 1'b1;
            cnt_nxt          = CNT_W'(DWELL - 1);
        end else if (state == GRANT && finish) begin
            gnt_nxt     = '0;
            valid_nxt   = 1'b0;
            done_nxt    = 1'b1;
            timeout_nxt = expire && !ack && req[idx];
            ptr_nxt     = idx + 2'd1;
        end else if (state == GRANT) begin
            cnt_nxt = (cnt == '0) ? cnt : cnt - 1'b1;
        end
    end
endmodule

// File: tb/tb_rr_mux_sel_ctrl.sv
// tb_rr_mux_sel_ctrl: directed and random stimulus against a grant-age reference model.
module tb_rr_mux_sel_ctrl;
    localparam int DWELL = 4;
    logic       clk = 1'b0;
    logic       rst, ack, s1, s2, valid, done, timeout;
    logic [3:0] req, gnt;
    logic       lk = 1'b0;
    int         n_chk = 0, n_fail = 0;
    bit         m_on, m_rel, m_to;
    int         m_ch, m_held, m_prio, m_sel;
    logic [3:0] seen[$];
    logic [3:0] prev;

    rr_mux_sel_ctrl #(.DWELL(DWELL), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .req(req), .ack(ack),
`ifdef RR_MUX_SEL_LOCK_EN
        .lock(lk),
`endif
        .s1(s1), .s2(s2), .gnt(gnt), .valid(valid), .done(done), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Model tracks which channel holds the grant and how many cycles it has held it
    task automatic model_step();
        bit expired;
        if (rst) begin
            m_on = 0; m_rel = 0; m_to = 0; m_prio = 0; m_sel = 0;
        end else if (m_on) begin
`ifdef RR_MUX_SEL_LOCK_EN
            expired = (m_held >= DWELL) && !lk;
`else
            expired = m_held >= DWELL;
`endif
            if (ack || !req[m_ch] || expired) begin
                m_on = 0; m_rel = 1;
                m_to = expired && !ack && req[m_ch];
                m_prio = (m_ch + 1) % 4;
            end else m_held++;
        end else if (m_rel) begin
            m_rel = 0; m_to = 0;
        end else if (req != 4'b0) begin
            for (int k = 3; k >= 0; k--) if (req[(m_prio + k) % 4]) m_ch = (m_prio + k) % 4;
            m_on = 1; m_held = 1; m_sel = m_ch;
        end
    endtask

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("gnt", gnt, m_on ? 4'(1 << m_ch) : 4'b0);
        chk("sel", {2'b0, s1, s2}, 4'(m_sel));
        chk("valid", {3'b0, valid}, {3'b0, m_on});
        chk("done", {3'b0, done}, {3'b0, m_rel});
        chk("timeout", {3'b0, timeout}, {3'b0, m_to});
    endtask

    task automatic step(input logic r, input logic [3:0] q, input logic a);
        rst = r; req = q; ack = a;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    // Acks each grant in its first cycle and records the grant order
    task automatic run_rr(input logic [3:0] r, input int n);
        seen.delete();
        for (int i = 0; i < 60 && seen.size() < n; i++) begin
            prev = gnt;
            step(1'b0, r, m_on && m_held == 1);
            if (gnt != 4'b0 && prev == 4'b0) seen.push_back(gnt);
        end
        chk("rr_count", 4'(seen.size()), 4'(n));
    endtask

    initial begin
        logic [3:0] rr_exp[5];
        logic [3:0] sp_exp[3];
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        sp_exp = '{4'b0010, 4'b1000, 4'b0010};
        rst = 1'b1; req = 4'b0; ack = 1'b0;
        // Reset with all requests pending
        step(1'b1, 4'hf, 1'b0);
        step(1'b1, 4'hf, 1'b0);
        chk("rst_gnt", gnt, 4'b0000);
        chk("rst_valid", {3'b0, valid}, 4'b0);
        step(1'b0, 4'hf, 1'b0);
        chk("first_gnt", gnt, 4'b0001);
        step(1'b0, 4'hf, 1'b1);
        step(1'b0, 4'h0, 1'b0);
        // Dwell expiry on a lone requester
        step(1'b1, 4'h0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 4'b0001, 1'b0);
            if (i < 4) chk("dwell_gnt", gnt, 4'b0001);
            if (i == 4) chk("dwell_done", {2'b0, done, timeout}, 4'b0011);
            if (i == 5) chk("dwell_gap", gnt, 4'b0000);
            if (i == 6) chk("dwell_regrant", gnt, 4'b0001);
        end
        // Round-robin with all channels requesting
        step(1'b1, 4'h0, 1'b0);
        run_rr(4'hf, 5);
        for (int i = 0; i < seen.size(); i++) chk("rr_order", seen[i], rr_exp[i]);
        // Sparse requests
        step(1'b1, 4'h0, 1'b0);
        run_rr(4'b1010, 3);
        for (int i = 0; i < seen.size(); i++) chk("sparse_order", seen[i], sp_exp[i]);
        // Request drop during a ch2 grant
        step(1'b1, 4'h0, 1'b0);
        step(1'b0, 4'b0100, 1'b0);
        step(1'b0, 4'b0100, 1'b0);
        step(1'b0, 4'b0000, 1'b0);
        chk("drop_done", {1'b0, gnt == 4'b0, done, timeout}, 4'b0110);
        step(1'b0, 4'hf, 1'b0);
        step(1'b0, 4'hf, 1'b0);
        chk("drop_next", gnt, 4'b1000);
        step(1'b0, 4'hf, 1'b1);
        step(1'b0, 4'h0, 1'b0);
        // Reset in the middle of a grant
        step(1'b1, 4'h0, 1'b0);
        step(1'b0, 4'b0001, 1'b0);
        step(1'b0, 4'b0001, 1'b0);
        step(1'b1, 4'b0001, 1'b0);
        chk("midrst_gnt", {gnt[3:1], valid | done}, 4'b0000);
        step(1'b0, 4'b0000, 1'b0);
        chk("midrst_nodone", {3'b0, done}, 4'b0);
`ifdef RR_MUX_SEL_LOCK_EN
        lk = 1'b1;
        for (int i = 0; i < 12; i++) step(1'b0, 4'b0001, 1'b0);
        chk("lock_hold", gnt, 4'b0001);
        step(1'b0, 4'b0001, 1'b1);
        chk("lock_done", {2'b0, done, timeout}, 4'b0010);
        lk = 1'b0;
        step(1'b0, 4'b0000, 1'b0);
`endif
        // Random traffic against the model
        for (int i = 0; i < 800; i++) begin
`ifdef RR_MUX_SEL_LOCK_EN
            if ($urandom_range(0, 15) == 0) lk = ~lk;
`endif
            step($urandom_range(0, 60) == 0,
                 ($urandom_range(0, 3) == 0) ? 4'($urandom) : req,
                 $urandom_range(0, 5) == 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
